// File: rtl/hex_display_bank.sv
// hex_display_bank: drives DIGITS active-low seven-segment digits from a binary value.
// The value is shown as hex, or as decimal after a WIDTH-cycle double-dabble conversion.
// The display can optionally blank leading zeros and blink. It shows dashes when the
// value does not fit in the available digits.
module hex_display_bank #(
  parameter int DIGITS    = 6,
  parameter int WIDTH     = 20,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      num,
  input  logic                  load,
  input  logic                  mode,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int EXT_W = (WIDTH > BCD_W) ? WIDTH : BCD_W;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  // Segment pattern for one hex nibble, bit6..bit0 = g..a, active low.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Conversion state.
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               conv_ovf_q, conv_ovf_d;

  // Display state.
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Blink state.
  logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               phase_q, phase_d;

  // Combinational helpers.
  logic [EXT_W-1:0]   num_ext;
  logic [BCD_W-1:0]   hex_disp;
  logic               hex_ovf;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_step;
  logic               step_ovf;
  logic [3:0]         digit;
  logic [6:0]         seg;
  logic               nz_seen;

  // Hex capture: zero-extend to the digit span, and flag any bits beyond it.
  always_comb begin
    num_ext  = EXT_W'(num);
    hex_disp = num_ext[BCD_W-1:0];
    hex_ovf  = |(num_ext >> BCD_W);
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  // A 1 leaving the top digit means the value no longer fits in DIGITS decimal places.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end
    step_ovf = bcd_adj[BCD_W-1];
    bcd_step = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
  end

  // Load acceptance and conversion sequencing.
  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    conv_ovf_d = conv_ovf_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (load) begin
          if (mode) begin
            state_d    = CONV;
            bin_d      = num;
            bcd_d      = '0;
            step_d     = '0;
            conv_ovf_d = 1'b0;
            busy_d     = 1'b1;
          end else begin
            disp_d  = hex_disp;
            ovf_d   = hex_ovf;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      CONV: begin
        // Loads are ignored here, so a request while busy is simply dropped.
        bin_d      = bin_q << 1;
        bcd_d      = bcd_step;
        conv_ovf_d = conv_ovf_q | step_ovf;
        step_d     = step_q + CNT_W'(1);
        if (step_q == LAST_STEP) begin
          disp_d  = bcd_step;
          ovf_d   = conv_ovf_q | step_ovf;
          valid_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Free-running blink divider: toggle the phase once every BLINK_DIV cycles.
  always_comb begin
    phase_d = phase_q;
    if (blk_cnt_q == BLK_LAST) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
    end
  end

  // State registers; reset aborts any conversion and blanks the display.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      conv_ovf_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      blk_cnt_q  <= '0;
      phase_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      conv_ovf_q <= conv_ovf_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      blk_cnt_q  <= blk_cnt_d;
      phase_q    <= phase_d;
    end
  end

  // Segment decode. Priority is blank (invalid or blink off), then dash (overflow),
  // then leading-zero blanking. The scan runs from the top digit down.
  always_comb begin
    nz_seen = 1'b0;
    digit   = '0;
    seg     = SEG_BLANK;
    HEX     = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit   = disp_q[4*i +: 4];
      nz_seen = nz_seen | (digit != 4'd0);
      if (!valid_q || (blink_en && !phase_q)) begin
        seg = SEG_BLANK;
      end else if (ovf_q) begin
        seg = SEG_DASH;
      end else if (blank_lz && !nz_seen && (i != 0)) begin
        seg = SEG_BLANK;
      end else begin
        seg = seg7(digit);
      end
      HEX[7*i +: 7] = seg;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank with DIGITS=6, WIDTH=20, BLINK_DIV=4.
module tb_hex_display_bank;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b0111111;
  localparam logic [41:0] ALL_OFF = {42{1'b1}};

  logic        clk;
  logic        resetn;
  logic [19:0] num;
  logic        load;
  logic        mode;
  logic        blank_lz;
  logic        blink_en;
  logic        busy;
  logic        done;
  logic [41:0] HEX;

  int checks = 0;
  int errors = 0;
  int busy_n;
  int done_n;
  logic [41:0] mid_hex;

  hex_display_bank #(.DIGITS(6), .WIDTH(20), .BLINK_DIV(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .num      (num),
    .load     (load),
    .mode     (mode),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .busy     (busy),
    .done     (done),
    .HEX      (HEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] pack6(input logic [6:0] d5, input logic [6:0] d4,
                                        input logic [6:0] d3, input logic [6:0] d2,
                                        input logic [6:0] d1, input logic [6:0] d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one load and run a fixed number of cycles, counting busy/done samples.
  task automatic run_load(input logic m, input logic [19:0] n, input int cycles);
    mode   = m;
    num    = n;
    load   = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      load   = 1'b0;
      busy_n += int'(busy);
      done_n += int'(done);
      if (i == 5) mid_hex = HEX;
    end
  endtask

  initial begin
    logic [41:0] on_pat;
    logic [15:0] s;
    int          bad;
    int          alt_err;
    int          steady_err;
    logic        got_done;

    resetn   = 1'b0;
    num      = '0;
    load     = 1'b0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    mid_hex  = '0;
    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hex",  64'(HEX), 64'(ALL_OFF));
    resetn = 1'b1;
    tick();
    check("idle_hex_invalid", 64'(HEX), 64'(ALL_OFF));

    // Hex load with leading-zero blanking; interior zero must stay visible.
    blank_lz = 1'b1;
    mode     = 1'b0;
    num      = 20'hA50F3;
    load     = 1'b1;
    tick();
    load   = 1'b0;
    check("hex_done",  64'(done), 64'd1);
    check("hex_busy",  64'(busy), 64'd0);
    check("hex_value", 64'(HEX), 64'(pack6(BL, SA, S5, S0, SF, S3)));
    done_n = int'(done);
    busy_n = int'(busy);
    repeat (4) begin
      tick();
      done_n += int'(done);
      busy_n += int'(busy);
    end
    check("hex_done_count", 64'(done_n), 64'd1);
    check("hex_busy_count", 64'(busy_n), 64'd0);

    // Decimal conversion; old display must persist during conversion.
    blank_lz = 1'b0;
    run_load(1'b1, 20'd12345, 25);
    check("dec_mid_hold",   64'(mid_hex), 64'(pack6(S0, SA, S5, S0, SF, S3)));
    check("dec_busy_count", 64'(busy_n), 64'd20);
    check("dec_done_count", 64'(done_n), 64'd1);
    check("dec_value",      64'(HEX), 64'(pack6(S0, S1, S2, S3, S4, S5)));
    blank_lz = 1'b1;
    #1;
    check("dec_blank_lz",   64'(HEX), 64'(pack6(BL, S1, S2, S3, S4, S5)));

    // Largest value that fits, then one that overflows.
    run_load(1'b1, 20'd999999, 25);
    check("dec_max_value", 64'(HEX), 64'(pack6(S9, S9, S9, S9, S9, S9)));
    run_load(1'b1, 20'hFFFFF, 25);
    check("dec_ovf_dash",  64'(HEX), 64'(pack6(DA, DA, DA, DA, DA, DA)));
    check("dec_ovf_done",  64'(done_n), 64'd1);

    // Load of 999 during cycle 3 of a 12345 conversion must be dropped.
    blank_lz = 1'b0;
    mode     = 1'b1;
    num      = 20'd12345;
    load     = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    num  = 20'd999;
    load = 1'b1;
    done_n = 0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      done_n += int'(done);
    end
    check("busy_load_value", 64'(HEX), 64'(pack6(S0, S1, S2, S3, S4, S5)));
    check("busy_load_done",  64'(done_n), 64'd1);

    // Load accepted in the cycle where done is high.
    blank_lz = 1'b1;
    mode     = 1'b1;
    num      = 20'd4321;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("b2b_first_done",  64'(got_done), 64'd1);
    check("b2b_first_value", 64'(HEX), 64'(pack6(BL, BL, S4, S3, S2, S1)));
    mode = 1'b0;
    num  = 20'h7;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("b2b_second_value", 64'(HEX), 64'(pack6(BL, BL, BL, BL, BL, S7)));
    check("b2b_second_done",  64'(done), 64'd1);

    // Reset at cycle 10 of a conversion.
    run_load(1'b1, 20'd12345, 10);
    check("abort_busy_before", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hex",  64'(HEX), 64'(ALL_OFF));
    check("abort_done", 64'(done), 64'd0);
    tick();
    resetn = 1'b1;
    done_n = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      done_n += int'(done);
    end
    check("abort_no_done",   64'(done_n), 64'd0);
    check("abort_hex_after", 64'(HEX), 64'(ALL_OFF));
    run_load(1'b0, 20'h7, 2);
    on_pat = pack6(BL, BL, BL, BL, BL, S7);
    check("abort_reload", 64'(HEX), 64'(on_pat));

    // Blink with BLINK_DIV=4: four cycles on, four cycles blank.
    blink_en = 1'b1;
    bad      = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      s[i] = (HEX == on_pat);
      if (!(HEX == on_pat || HEX == ALL_OFF)) bad++;
    end
    alt_err = 0;
    for (int i = 0; i < 12; i++) begin
      if (s[i+4] == s[i]) alt_err++;
    end
    check("blink_patterns", 64'(bad), 64'd0);
    check("blink_on_count", 64'($countones(s)), 64'd8);
    check("blink_alternate", 64'(alt_err), 64'd0);
    blink_en   = 1'b0;
    steady_err = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (HEX !== on_pat) steady_err++;
    end
    check("blink_off_steady", 64'(steady_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
